// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table response checker.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } tt_state_e;

  // Number of truth-table rows for an n-input gate.
  function automatic int tt_depth(input int n);
    return 1 << n;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= m) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/truth_table_checker.sv
// Response-side checker for exhaustive gate sweeps: captures f per input
// vector, counts mismatches against EXPECTED, and flags unstable outputs.
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int                      N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = 16'h6996,
  parameter int                      MCNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [N_IN-1:0]               in_vec,
  input  logic                          in_f,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [tt_depth(N_IN)-1:0]     captured,
  output logic [tt_depth(N_IN)-1:0]     seen,
  output logic [MCNT_W-1:0]             mismatch_cnt,
  output logic [N_IN-1:0]               first_fail,
  output logic                          first_fail_vld,
  output logic                          unstable
);

  localparam int DEPTH = tt_depth(N_IN);

  tt_state_e          state_q;
  logic               busy_q, done_q;
  logic [DEPTH-1:0]   captured_q, captured_d;
  logic [DEPTH-1:0]   seen_q, seen_d;
  logic [MCNT_W-1:0]  mcnt_q, mcnt_d;
  logic [N_IN-1:0]    ff_q, ff_d;
  logic               ffv_q, ffv_d;
  logic               unstable_q, unstable_d;

  // Result update for one sample; start wins and drops its own sample.
  always_comb begin
    captured_d = captured_q;
    seen_d     = seen_q;
    mcnt_d     = mcnt_q;
    ff_d       = ff_q;
    ffv_d      = ffv_q;
    unstable_d = unstable_q;
    if (start) begin
      captured_d = '0;
      seen_d     = '0;
      mcnt_d     = '0;
      ff_d       = '0;
      ffv_d      = 1'b0;
      unstable_d = 1'b0;
    end else if (state_q == COLLECT && in_valid) begin
      // First sample of a vector is the reference; later ones only check it.
      if (!seen_q[in_vec]) begin
        captured_d[in_vec] = in_f;
        seen_d[in_vec]     = 1'b1;
      end else if (in_f != captured_q[in_vec]) begin
        unstable_d = 1'b1;
      end
      if (in_f != EXPECTED[in_vec]) begin
        mcnt_d = MCNT_W'(sat_inc(32'(mcnt_q), MCNT_W));
        if (!ffv_q) begin
          ff_d  = in_vec;
          ffv_d = 1'b1;
        end
      end
    end
  end

  // Control FSM with registered busy/done, plus the result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      captured_q <= '0;
      seen_q     <= '0;
      mcnt_q     <= '0;
      ff_q       <= '0;
      ffv_q      <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      captured_q <= captured_d;
      seen_q     <= seen_d;
      mcnt_q     <= mcnt_d;
      ff_q       <= ff_d;
      ffv_q      <= ffv_d;
      unstable_q <= unstable_d;
      if (start) begin
        state_q <= COLLECT;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          COLLECT: begin
            if (in_valid && (&seen_d)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          DONE: begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = (state_q == DONE) && (mcnt_q == '0) && !unstable_q;
  assign captured       = captured_q;
  assign seen           = seen_q;
  assign mismatch_cnt   = mcnt_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;
  assign unstable       = unstable_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with hand-computed expectations.
module tb_truth_table_checker;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_f;
  logic [3:0]  in_vec;
  logic        busy, done, pass, first_fail_vld, unstable;
  logic [15:0] captured, seen;
  logic [7:0]  mismatch_cnt;
  logic [3:0]  first_fail;

  logic [15:0] exp_tt = 16'h6996;
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.N_IN(4), .EXPECTED(16'h6996), .MCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_vec(in_vec), .in_f(in_f), .busy(busy), .done(done), .pass(pass),
    .captured(captured), .seen(seen), .mismatch_cnt(mismatch_cnt),
    .first_fail(first_fail), .first_fail_vld(first_fail_vld),
    .unstable(unstable)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v, input logic f);
    in_valid = 1'b1; in_vec = v; in_f = f;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends vectors lo..hi with f = expected ^ flip[k].
  task automatic send_range(input int lo, input int hi, input logic [15:0] flip);
    for (int k = lo; k <= hi; k++) send(4'(k), exp_tt[k] ^ flip[k]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_vec = '0; in_f = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({busy, done, pass, first_fail_vld, unstable} !== 5'b0 || captured !== 16'h0 ||
        seen !== 16'h0 || mismatch_cnt !== 8'h0 || first_fail !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b cap=%h seen=%h mc=%0d ff=%0d ffv=%b unst=%b required all zero",
               busy, done, pass, captured, seen, mismatch_cnt, first_fail, first_fail_vld, unstable);
    end
    send(4'd2, 1'b1); send(4'd7, 1'b0);
    n_chk++;
    if (seen !== 16'h0 || mismatch_cnt !== 8'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: seen=%h mc=%0d busy=%b required 0000 0 0", seen, mismatch_cnt, busy);
    end
  endtask

  task automatic test_full_pass();
    pulse_start();
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL pass_busy: busy=%b done=%b required 1 0", busy, done);
    end
    send_range(0, 14, 16'h0);
    n_chk++;
    if (done !== 1'b0 || seen !== 16'h7FFF) begin
      n_fail++; $display("FAIL pass_before_last: done=%b seen=%h required 0 7fff", done, seen);
    end
    send_range(15, 15, 16'h0);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || captured !== 16'h6996 ||
        mismatch_cnt !== 8'd0 || first_fail_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_result: done=%b busy=%b pass=%b cap=%h mc=%0d ffv=%b required 1 0 1 6996 0 0",
               done, busy, pass, captured, mismatch_cnt, first_fail_vld);
    end
  endtask

  task automatic test_done_ignores_valid();
    send(4'd0, 1'b1);
    n_chk++;
    if (mismatch_cnt !== 8'd0 || unstable !== 1'b0 || done !== 1'b1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ignores_valid: mc=%0d unst=%b done=%b pass=%b required 0 0 1 1",
               mismatch_cnt, unstable, done, pass);
    end
  endtask

  task automatic test_single_fault();
    pulse_start();
    n_chk++;
    if (done !== 1'b0 || seen !== 16'h0 || captured !== 16'h0) begin
      n_fail++; $display("FAIL fault_start_clear: done=%b seen=%h cap=%h required 0 0 0", done, seen, captured);
    end
    send_range(0, 15, 16'h0020);
    n_chk++;
    if (done !== 1'b1 || captured !== 16'h69B6 || mismatch_cnt !== 8'd1 ||
        first_fail !== 4'd5 || first_fail_vld !== 1'b1 || pass !== 1'b0 || unstable !== 1'b0) begin
      n_fail++;
      $display("FAIL single_fault: done=%b cap=%h mc=%0d ff=%0d ffv=%b pass=%b unst=%b required 1 69b6 1 5 1 0 0",
               done, captured, mismatch_cnt, first_fail, first_fail_vld, pass, unstable);
    end
  endtask

  task automatic test_unstable();
    pulse_start();
    send(4'd3, 1'b0);
    send(4'd3, 1'b1);
    n_chk++;
    if (unstable !== 1'b1 || captured[3] !== 1'b0 || mismatch_cnt !== 8'd1 || first_fail !== 4'd3) begin
      n_fail++;
      $display("FAIL unstable_dup: unst=%b cap3=%b mc=%0d ff=%0d required 1 0 1 3",
               unstable, captured[3], mismatch_cnt, first_fail);
    end
    send_range(0, 2, 16'h0);
    send_range(4, 15, 16'h0);
    n_chk++;
    if (done !== 1'b1 || captured !== 16'h6996 || mismatch_cnt !== 8'd1 ||
        first_fail !== 4'd3 || first_fail_vld !== 1'b1 || unstable !== 1'b1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL unstable_result: done=%b cap=%h mc=%0d ff=%0d ffv=%b unst=%b pass=%b required 1 6996 1 3 1 1 0",
               done, captured, mismatch_cnt, first_fail, first_fail_vld, unstable, pass);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    send_range(0, 9, 16'h0001);
    // Start carries a sample that must be dropped.
    start = 1'b1; in_valid = 1'b1; in_vec = 4'd12; in_f = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (seen !== 16'h0 || mismatch_cnt !== 8'd0 || first_fail_vld !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: seen=%h mc=%0d ffv=%b busy=%b required 0000 0 0 1",
               seen, mismatch_cnt, first_fail_vld, busy);
    end
    send_range(0, 14, 16'h0);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL restart_early_done: done=%b required 0", done);
    end
    send_range(15, 15, 16'h0);
    n_chk++;
    if (done !== 1'b1 || pass !== 1'b1 || captured !== 16'h6996) begin
      n_fail++; $display("FAIL restart_result: done=%b pass=%b cap=%h required 1 1 6996", done, pass, captured);
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    send_range(0, 6, 16'h0004);
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_vec = 4'd9; in_f = 1'b0;
    tick();
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (seen !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || mismatch_cnt !== 8'd0 || first_fail_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: seen=%h busy=%b done=%b mc=%0d ffv=%b required 0000 0 0 0 0",
               seen, busy, done, mismatch_cnt, first_fail_vld);
    end
    pulse_start();
    send_range(0, 15, 16'h0);
    n_chk++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_resweep: done=%b pass=%b required 1 1", done, pass);
    end
  endtask

  task automatic test_saturate();
    pulse_start();
    for (int i = 0; i < 300; i++) send(4'd0, 1'b1);
    n_chk++;
    if (mismatch_cnt !== 8'hFF || first_fail !== 4'd0 || first_fail_vld !== 1'b1 ||
        unstable !== 1'b0 || busy !== 1'b1 || seen !== 16'h0001) begin
      n_fail++;
      $display("FAIL saturate: mc=%0d ff=%0d ffv=%b unst=%b busy=%b seen=%h required 255 0 1 0 1 0001",
               mismatch_cnt, first_fail, first_fail_vld, unstable, busy, seen);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_done_ignores_valid();
    test_single_fault();
    test_unstable();
    test_restart();
    test_mid_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
